mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arbiter_buffer.sv | 35 +++
 rtl/mem_arbiter.sv | 102 ++++++++++
 tb/tb_mem_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and owner encodings for the two-master memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_t;
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I = 2'd1;
  localparam logic [1:0] OWN_D = 2'd2;
  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;
endpackage

// File: rtl/mem_arbiter_buffer.sv
// mem_arbiter_buffer: per-master request capture register with pending flag and violation detect
module mem_arbiter_buffer
  import mem_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     valid_i,
  input  mem_req_t req_i,
  input  logic     clr_i,
  input  logic     owner_i,
  output logic     pending_o,
  output mem_req_t req_o,
  output logic     err_o
);
  logic     pending_q, pending_d, accept;
  mem_req_t req_q, req_d;
  assign err_o = valid_i & (pending_q | owner_i);
  assign accept = valid_i & ~err_o;
  // clear beats set so a request granted straight from the live inputs never lingers as pending
  always_comb begin
    pending_d = clr_i ? 1'b0 : (accept | pending_q);
    req_d = accept ? req_i : req_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
      req_q <= '0;
    end else begin
      pending_q <= pending_d;
      req_q <= req_d;
    end
  end
  assign pending_o = pending_q;
  assign req_o = req_q;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-master to one-slave request arbiter
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit PRIORITY_DATA = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemory_valid,
  input  logic        imemory_instr,
  input  logic [31:0] imemory_addr,
  input  logic [31:0] imemory_wdata,
  input  logic [3:0]  imemory_wstrb,
  output logic [31:0] imemory_rdata,
  output logic        imemory_ready,
  input  logic        dmemory_valid,
  input  logic        dmemory_instr,
  input  logic [31:0] dmemory_addr,
  input  logic [31:0] dmemory_wdata,
  input  logic [3:0]  dmemory_wstrb,
  output logic [31:0] dmemory_rdata,
  output logic        dmemory_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        arb_error
);
  arb_state_t state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic       last_q, last_d, err_q, err_d;
  mem_req_t   req_q, req_d, i_live, d_live, i_buf, d_buf, src;
  logic       i_pend, d_pend, i_err, d_err, i_clr, d_clr, ri, rd, gnt_d, done;
  assign i_live = '{imemory_instr, imemory_addr, imemory_wdata, imemory_wstrb};
  assign d_live = '{dmemory_instr, dmemory_addr, dmemory_wdata, dmemory_wstrb};
  mem_arbiter_buffer u_ibuf (
    .clk(clk), .rst(rst), .valid_i(imemory_valid), .req_i(i_live), .clr_i(i_clr),
    .owner_i(owner_q == OWN_I), .pending_o(i_pend), .req_o(i_buf), .err_o(i_err)
  );
  mem_arbiter_buffer u_dbuf (
    .clk(clk), .rst(rst), .valid_i(dmemory_valid), .req_i(d_live), .clr_i(d_clr),
    .owner_i(owner_q == OWN_D), .pending_o(d_pend), .req_o(d_buf), .err_o(d_err)
  );
  assign ri = i_pend | imemory_valid;
  assign rd = d_pend | dmemory_valid;
  // last_q = 1 means data won last, so a tie goes to instruction
  assign gnt_d = rd & (~ri | ~last_q);
  // a live pulse on an already-pending master is a dropped violation, so the buffer wins then
  assign src = gnt_d ? (d_pend ? d_buf : d_live) : (i_pend ? i_buf : i_live);
  assign done = (state_q != ARB_IDLE) & mem_ready;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    req_d = req_q;
    i_clr = 1'b0;
    d_clr = 1'b0;
    err_d = err_q | i_err | d_err;
    unique case (state_q)
      ARB_IDLE: if (ri | rd) begin
        state_d = ARB_ISSUE;
        owner_d = gnt_d ? OWN_D : OWN_I;
        last_d = gnt_d;
        req_d = src;
        i_clr = ~gnt_d;
        d_clr = gnt_d;
      end
      ARB_ISSUE: state_d = mem_ready ? ARB_IDLE : ARB_WAIT;
      ARB_WAIT: state_d = mem_ready ? ARB_IDLE : ARB_WAIT;
      default: state_d = ARB_IDLE;
    endcase
    owner_d = done ? OWN_NONE : owner_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_NONE;
      last_q <= ~PRIORITY_DATA;
      err_q <= 1'b0;
      req_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      err_q <= err_d;
      req_q <= req_d;
    end
  end
  assign mem_valid = state_q == ARB_ISSUE;
  assign mem_instr = req_q.instr;
  assign mem_addr = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_wstrb = req_q.wstrb;
  assign imemory_ready = done & (owner_q == OWN_I);
  assign dmemory_ready = done & (owner_q == OWN_D);
  assign imemory_rdata = imemory_ready ? mem_rdata : '0;
  assign dmemory_rdata = dmemory_ready ? mem_rdata : '0;
  assign arb_error = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        iv = 0, ii = 0, dv = 0, di = 0, mem_ready = 0;
  logic [31:0] ia = 0, iw = 0, da = 0, dw = 0, mem_rdata = 0;
  logic [3:0]  is = 0, ds = 0;
  logic [31:0] irdata, drdata, mem_addr, mem_wdata;
  logic        iready, dready, mem_valid, mem_instr, arb_error;
  logic [3:0]  mem_wstrb;
  int          checks = 0, errors = 0;
  mem_arbiter #(.PRIORITY_DATA(1'b1)) dut (
    .clk(clk), .rst(rst),
    .imemory_valid(iv), .imemory_instr(ii), .imemory_addr(ia), .imemory_wdata(iw), .imemory_wstrb(is),
    .imemory_rdata(irdata), .imemory_ready(iready),
    .dmemory_valid(dv), .dmemory_instr(di), .dmemory_addr(da), .dmemory_wdata(dw), .dmemory_wstrb(ds),
    .dmemory_rdata(drdata), .dmemory_ready(dready),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .arb_error(arb_error)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic pi, input logic pd);
    iv = pi;
    dv = pd;
    cyc();
    iv = 0;
    dv = 0;
  endtask
  task automatic issue_chk(input string tag, input logic instr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
    check({tag, "_valid"}, 32'(mem_valid), 32'd1);
    check({tag, "_instr"}, 32'(mem_instr), 32'(instr));
    check({tag, "_addr"}, mem_addr, addr);
    check({tag, "_wdata"}, mem_wdata, wdata);
    check({tag, "_wstrb"}, 32'(mem_wstrb), 32'(wstrb));
  endtask
  task automatic done(input string tag, input logic is_d, input logic [31:0] rd);
    mem_ready = 1;
    mem_rdata = rd;
    #1;
    check({tag, "_iready"}, 32'(iready), 32'(!is_d));
    check({tag, "_dready"}, 32'(dready), 32'(is_d));
    check({tag, "_irdata"}, irdata, is_d ? 32'd0 : rd);
    check({tag, "_drdata"}, drdata, is_d ? rd : 32'd0);
    cyc();
    mem_ready = 0;
    mem_rdata = 0;
  endtask
  task automatic serve(input string tag, input logic is_d, input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb, input logic [31:0] rd);
    issue_chk(tag, instr, addr, wdata, wstrb);
    cyc();
    check({tag, "_wait_valid"}, 32'(mem_valid), 32'd0);
    check({tag, "_wait_addr"}, mem_addr, addr);
    done(tag, is_d, rd);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(mem_valid), 0);
    check("rst_addr", mem_addr, 0);
    check("rst_err", 32'(arb_error), 0);
    check("rst_ready", 32'({iready, dready}), 0);
    rst = 0;
    cyc();
    // simultaneous pair right after reset: data first, instruction one transaction later
    ii = 1; ia = 32'h200; di = 0; da = 32'h300;
    pulse(1, 1);
    serve("pair1_d", 1, 0, 32'h300, 0, 0, 32'h11);
    check("pair1_gap", 32'(mem_valid), 0);
    cyc();
    serve("pair1_i", 0, 1, 32'h200, 0, 0, 32'h22);
    // single instruction read with a two-cycle wait before ready
    ia = 32'h100;
    iv = 1;
    #1 check("single_idle_valid", 32'(mem_valid), 0);
    cyc();
    iv = 0;
    issue_chk("single", 1, 32'h100, 0, 0);
    cyc();
    cyc();
    check("single_hold", mem_addr, 32'h100);
    done("single", 0, 32'hDEADBEEF);
    // solo data read makes data the last winner, so the next tie goes to instruction
    da = 32'h400;
    pulse(0, 1);
    serve("solo_d", 1, 0, 32'h400, 0, 0, 32'h44);
    ia = 32'h500; da = 32'h600;
    pulse(1, 1);
    serve("pair2_i", 0, 1, 32'h500, 0, 0, 32'h55);
    cyc();
    serve("pair2_d", 1, 0, 32'h600, 0, 0, 32'h66);
    // data write arriving while instruction owns is buffered and issued unchanged
    ia = 32'h700;
    pulse(1, 0);
    issue_chk("busy_i", 1, 32'h700, 0, 0);
    da = 32'h0010_0004; dw = 32'h1234_5678; ds = 4'hF;
    pulse(0, 1);
    da = 0; dw = 0; ds = 0;
    done("busy_i", 0, 32'h77);
    cyc();
    serve("busy_w", 1, 0, 32'h0010_0004, 32'h1234_5678, 4'hF, 32'h0);
    check("busy_err", 32'(arb_error), 0);
    // second instruction pulse while the first is pending is dropped and flagged
    da = 32'h800;
    pulse(0, 1);
    ia = 32'h900;
    pulse(1, 0);
    ia = 32'hA00;
    pulse(1, 0);
    check("viol_err", 32'(arb_error), 1);
    done("viol_d", 1, 32'h88);
    cyc();
    serve("viol_i", 0, 1, 32'h900, 0, 0, 32'h99);
    check("viol_idle", 32'(mem_valid), 0);
    // zero-wait slave completes in the issue cycle
    ia = 32'hB00;
    pulse(1, 0);
    check("zw_valid", 32'(mem_valid), 1);
    done("zw", 0, 32'hBB);
    check("zw_idle", 32'(mem_valid), 0);
    cyc();
    check("zw_noreissue", 32'(mem_valid), 0);
    // async reset while waiting, then a stray ready must be ignored
    da = 32'hC00;
    pulse(0, 1);
    cyc();
    #2 rst = 1;
    #1;
    check("arst_valid", 32'(mem_valid), 0);
    check("arst_addr", mem_addr, 0);
    check("arst_err", 32'(arb_error), 0);
    cyc();
    rst = 0;
    mem_ready = 1;
    mem_rdata = 32'hCAFE;
    #1;
    check("stray_ready", 32'({iready, dready}), 0);
    check("stray_rdata", irdata | drdata, 0);
    cyc();
    mem_ready = 0;
    cyc();
    check("stray_idle", 32'(mem_valid), 0);
    check("stray_addr", mem_addr, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
